// File: rtl/conv1_window_xor.sv
// conv1_window_xor: raster pixel stream -> KxK sliding windows XORed with
// the replicated binary kernel bits, one window word per valid/ready transfer.
// Optional build macro CONV1_STALL_CNT_EN adds the 16-bit o_stall_cnt port.
module conv1_window_xor #(
   parameter int bW    = 8,
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int K     = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_pix_valid,
   output logic                       o_pix_ready,
   input  logic [bW-1:0]              i_pix,
   input  logic [K*K-1:0]             i_kernel_bits,
   output logic                       o_win_valid,
   input  logic                       i_win_ready,
   output logic [0:K*K*bW-1]          o_win_xor,
   output logic [$clog2(IMG_H)-1:0]   o_win_row,
   output logic [$clog2(IMG_W)-1:0]   o_win_col,
   output logic                       o_frame_done
`ifdef CONV1_STALL_CNT_EN
   ,
   output logic [15:0]                o_stall_cnt
`endif
);

   localparam int RW     = $clog2(IMG_H);
   localparam int CW     = $clog2(IMG_W);
   localparam int LANES  = K * K;
   // History of previously accepted pixels; the newest pixel itself is tap 0.
   localparam int SR_LEN = (K - 1) * IMG_W + (K - 1);

   typedef enum logic [1:0] {FILL, RUN, DONE} state_t;

   state_t              state_reg, state_next;
   logic [RW-1:0]       row_reg;
   logic [CW-1:0]       col_reg;
   logic [LANES-1:0]    kbits_reg;
   logic [bW-1:0]       sr_reg [SR_LEN];
   logic [bW-1:0]       tap [LANES];
   logic [0:LANES*bW-1] xor_next;
   logic                win_valid_reg;
   logic                frame_done_reg;

   logic accept, at_last_col, at_last_row, frame_start, win_complete, frame_end;

   assign o_pix_ready  = !(win_valid_reg && !i_win_ready) && (state_reg != DONE);
   assign accept       = i_pix_valid && o_pix_ready;
   assign at_last_col  = (col_reg == CW'(IMG_W - 1));
   assign at_last_row  = (row_reg == RW'(IMG_H - 1));
   assign frame_start  = accept && (row_reg == '0) && (col_reg == '0);
   assign win_complete = accept && (row_reg >= RW'(K - 1)) && (col_reg >= CW'(K - 1));
   // Last window has been handed over (or none is pending) while draining.
   assign frame_end    = (state_reg == DONE) && (!win_valid_reg || i_win_ready);

   assign o_win_valid  = win_valid_reg;
   assign o_frame_done = frame_done_reg;

   // Window lane (r,c) is the pixel (K-1-r) rows and (K-1-c) columns behind the newest one.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         localparam int R = gi / K;
         localparam int C = gi % K;
         localparam int D = (K - 1 - R) * IMG_W + (K - 1 - C);
         if (D == 0) begin : g_new
            assign tap[gi] = i_pix;
         end else begin : g_hist
            assign tap[gi] = sr_reg[D-1];
         end
         assign xor_next[gi*bW +: bW] = tap[gi] ^ {bW{kbits_reg[gi]}};
      end
   endgenerate

   // Pixel history shift register; contents are don't-care until refilled.
   always_ff @(posedge clk) begin
      if (accept) begin
         sr_reg[0] <= i_pix;
         for (int i = SR_LEN - 1; i > 0; i--)
            sr_reg[i] <= sr_reg[i-1];
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_reg <= FILL;
      else     state_reg <= state_next;
   end

   // FSM next-state: fill K-1 rows, run to the last pixel, drain the last window.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         FILL: if (accept && at_last_col && (row_reg == RW'(K - 2))) state_next = RUN;
         RUN:  if (accept && at_last_col && at_last_row) state_next = DONE;
         DONE: if (frame_end) state_next = FILL;
         default: state_next = FILL;
      endcase
   end

   // Raster row/column position of the next pixel to be accepted.
   always_ff @(posedge clk) begin
      if (rst || frame_end) begin
         row_reg <= '0;
         col_reg <= '0;
      end else if (accept) begin
         if (at_last_col) begin
            col_reg <= '0;
            row_reg <= at_last_row ? '0 : row_reg + 1'b1;
         end else begin
            col_reg <= col_reg + 1'b1;
         end
      end
   end

   // Kernel bits are frozen at the first pixel of each frame.
   always_ff @(posedge clk) begin
      if (rst)              kbits_reg <= '0;
      else if (frame_start) kbits_reg <= i_kernel_bits;
   end

   // Output window register: load on completion, hold while stalled, clear on handoff.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_valid_reg <= 1'b0;
         o_win_xor     <= '0;
         o_win_row     <= '0;
         o_win_col     <= '0;
      end else if (win_complete) begin
         win_valid_reg <= 1'b1;
         o_win_xor     <= xor_next;
         o_win_row     <= row_reg - RW'(K - 1);
         o_win_col     <= col_reg - CW'(K - 1);
      end else if (i_win_ready) begin
         win_valid_reg <= 1'b0;
      end
   end

   // One-cycle end-of-frame pulse after the final window handshake.
   always_ff @(posedge clk) begin
      if (rst) frame_done_reg <= 1'b0;
      else     frame_done_reg <= frame_end;
   end

`ifdef CONV1_STALL_CNT_EN
   logic [15:0] stall_cnt_reg;
   assign o_stall_cnt = stall_cnt_reg;

   // Saturating count of cycles a window waits on downstream, per frame.
   always_ff @(posedge clk) begin
      if (rst || frame_start)
         stall_cnt_reg <= '0;
      else if (win_valid_reg && !i_win_ready && (stall_cnt_reg != 16'hFFFF))
         stall_cnt_reg <= stall_cnt_reg + 16'd1;
   end
`endif

endmodule

// File: tb/tb_conv1_window_xor.sv
// tb_conv1_window_xor: directed frames for conv1_window_xor (28x28, K=5, bW=8).
module tb_conv1_window_xor;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_pix_valid;
   logic          o_pix_ready;
   logic [7:0]    i_pix;
   logic [24:0]   i_kernel_bits;
   logic          o_win_valid;
   logic          i_win_ready;
   logic [0:199]  o_win_xor;
   logic [4:0]    o_win_row;
   logic [4:0]    o_win_col;
   logic          o_frame_done;
`ifdef CONV1_STALL_CNT_EN
   logic [15:0]   o_stall_cnt;
`endif

   int checks_cnt = 0;
   int errors_cnt = 0;

   conv1_window_xor #(.bW(8), .IMG_W(28), .IMG_H(28), .K(5)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_pix_valid   (i_pix_valid),
      .o_pix_ready   (o_pix_ready),
      .i_pix         (i_pix),
      .i_kernel_bits (i_kernel_bits),
      .o_win_valid   (o_win_valid),
      .i_win_ready   (i_win_ready),
      .o_win_xor     (o_win_xor),
      .o_win_row     (o_win_row),
      .o_win_col     (o_win_col),
      .o_frame_done  (o_frame_done)
`ifdef CONV1_STALL_CNT_EN
      ,
      .o_stall_cnt   (o_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Reference window from image coordinates: pixel (y,x) = (y*28+x) & 8'hFF.
   function automatic logic [0:199] ref_win(input int r, input int c, input logic [24:0] kb);
      logic [0:199] w;
      for (int n = 0; n < 25; n++) begin
         int y, x;
         logic [7:0] p;
         y = r + n / 5;
         x = c + n % 5;
         p = 8'((y * 28 + x) & 255);
         w[n*8 +: 8] = p ^ {8{kb[n]}};
      end
      return w;
   endfunction

   // mode 0: ready always 1; mode 1: ready 1-of-3 cycles; mode 2: first window held 10 cycles.
   // abort_at > 0: reset after that many pixels have been accepted.
   task automatic run_frame(input string name, input logic [24:0] kb0, input logic [24:0] kb1,
                            input int mode, input int abort_at,
                            input logic [7:0] exp_l0, input logic [7:0] exp_l24);
      int pix_idx = 0, win_idx = 0, cyc = 0, done_cnt = 0, stall_left = 10;
      logic exp_valid = 1'b0, load = 1'b0, prev_stall = 1'b0, rdy, exp_rdy;
      logic [4:0] exp_r = '0, exp_c = '0, prev_r = '0, prev_c = '0;
      logic [0:199] prev_xor = '0;
      bit finished = 0;
      while (!finished) begin
         @(negedge clk);
         cyc++;
         check_val("win_valid", o_win_valid, exp_valid);
         if (load) begin
            check_val("load_row", o_win_row, exp_r);
            check_val("load_col", o_win_col, exp_c);
         end
         if (prev_stall) begin
            check_val("hold_xor", o_win_xor, prev_xor);
            check_val("hold_row", o_win_row, prev_r);
            check_val("hold_col", o_win_col, prev_c);
         end
         if (o_frame_done) begin
            done_cnt++;
`ifdef CONV1_STALL_CNT_EN
            if (mode == 2) check_val("stall_cnt", o_stall_cnt, 16'd10);
`endif
         end
         case (mode)
            0: rdy = 1'b1;
            1: rdy = (cyc % 3 == 0);
            default: begin
               if (o_win_valid && stall_left > 0) begin
                  rdy = 1'b0;
                  stall_left--;
               end else rdy = 1'b1;
            end
         endcase
         i_win_ready   = rdy;
         i_pix_valid   = (pix_idx < 784);
         i_pix         = pix_idx[7:0];
         i_kernel_bits = (pix_idx == 0) ? kb0 : kb1;
         #1;
         exp_rdy = (o_win_valid && !rdy) ? 1'b0 : ((pix_idx < 784) || (done_cnt > 0));
         check_val("pix_ready", o_pix_ready, exp_rdy);
         if (o_win_valid && rdy) begin
            check_val("win_xor", o_win_xor, ref_win(win_idx / 24, win_idx % 24, kb0));
            check_val("win_row", o_win_row, win_idx / 24);
            check_val("win_col", o_win_col, win_idx % 24);
            if (win_idx == 0) begin
               check_val("lane0", o_win_xor[0 +: 8], exp_l0);
               check_val("lane24", o_win_xor[192 +: 8], exp_l24);
            end
            win_idx++;
         end
         load = 1'b0;
         if (i_pix_valid && o_pix_ready) begin
            if (pix_idx / 28 >= 4 && pix_idx % 28 >= 4) begin
               load  = 1'b1;
               exp_r = 5'(pix_idx / 28 - 4);
               exp_c = 5'(pix_idx % 28 - 4);
            end
            pix_idx++;
         end
         prev_stall = o_win_valid && !rdy;
         prev_xor   = o_win_xor;
         prev_r     = o_win_row;
         prev_c     = o_win_col;
         exp_valid  = load || prev_stall;
         if (abort_at > 0 && pix_idx == abort_at) finished = 1;
         if (done_cnt > 0) finished = 1;
         if (cyc > 6000) begin
            check_val("timeout", 1, 0);
            finished = 1;
         end
      end
      if (abort_at > 0) begin
         @(negedge clk);
         rst = 1'b1;
         i_pix_valid = 1'b0;
         @(negedge clk);
         rst = 1'b0;
         check_val("abort_valid", o_win_valid, 0);
         check_val("abort_ready", o_pix_ready, 1);
         for (int i = 0; i < 5; i++) begin
            if (o_frame_done) done_cnt++;
            @(negedge clk);
         end
         check_val("abort_done", done_cnt, 0);
      end else begin
         check_val("win_count", win_idx, 576);
         check_val("frame_done", done_cnt, 1);
      end
      $display("frame %s windows %0d done %0d cycles %0d", name, win_idx, done_cnt, cyc);
   endtask

   initial begin
      rst = 1'b1;
      i_pix_valid = 1'b0;
      i_pix = '0;
      i_kernel_bits = '0;
      i_win_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_val("rst_valid", o_win_valid, 0);
      check_val("rst_done", o_frame_done, 0);
      check_val("rst_xor", o_win_xor, 0);
      check_val("rst_row", o_win_row, 0);
      check_val("rst_col", o_win_col, 0);
      check_val("rst_ready", o_pix_ready, 1);
      rst = 1'b0;

      run_frame("plain",   25'h0,       25'h0,        0, 0,   8'h00, 8'h74);
      run_frame("invert",  25'h1FFFFFF, 25'h1FFFFFF,  0, 0,   8'hFF, 8'h8B);
      run_frame("ready3",  25'h0,       25'h0,        1, 0,   8'h00, 8'h74);
      run_frame("kbchg",   25'h1555555, 25'h0AAAAAA,  0, 0,   8'hFF, 8'h8B);
      run_frame("abort",   25'h0,       25'h0,        0, 300, 8'h00, 8'h74);
      run_frame("after",   25'h0,       25'h0,        0, 0,   8'h00, 8'h74);
      run_frame("stall10", 25'h0,       25'h0,        2, 0,   8'h00, 8'h74);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule

// File: doc/conv1_window_xor.md
Name: conv1_window_xor

Overview:
- Producer for the layer-1 binary accumulators. Takes a raster-order stream of bW-bit input pixels and builds a KxK sliding window with line buffers.
- For each valid (un-padded) window position, emits the window XORed lane-by-lane with the replicated binary kernel bits.
- Output is one window word per transfer over valid/ready; the downstream accumulate/binarize stage consumes it.
- Default geometry: 28x28 image, 5x5 kernel, 24x24 = 576 windows per frame.

Parameters:
- bW, 8, pixel width in bits.
- IMG_W, 28, image width in pixels.
- IMG_H, 28, image height in pixels.
- K, 5, kernel edge length; window has K*K lanes.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous active-high reset.
- i_pix_valid  in  1  input pixel valid.
- o_pix_ready  out  1  block can accept a pixel this cycle.
- i_pix  in  bW  input pixel, raster order, row 0 col 0 first.
- i_kernel_bits  in  K*K  kernel sign bits; index 0 = top-left, row-major.
- o_win_valid  out  1  window word valid.
- i_win_ready  in  1  downstream accepts the window word.
- o_win_xor  out  [0:K*K*bW-1]  lane n at [n*bW:(n+1)*bW-1]; lane 0 = top-left, row-major.
- o_win_row  out  $clog2(IMG_H)  output-map row of the window (0..IMG_H-K).
- o_win_col  out  $clog2(IMG_W)  output-map col of the window (0..IMG_W-K).
- o_frame_done  out  1  one-cycle pulse after the last window of a frame is consumed.

Behaviour:
- Reset: o_win_valid=0, o_frame_done=0, o_win_xor=0, o_win_row=0, o_win_col=0, o_pix_ready=1. State=FILL; row/col counters=0; line buffers need not be cleared.
- Pixel accept: i_pix_valid && o_pix_ready. o_pix_ready = !(o_win_valid && !i_win_ready) && state!=DONE.
- On each accept:
  - pixel shifts into the K-row line buffer / window registers;
  - col increments; at IMG_W-1 it wraps to 0 and row increments.
- Window completion: the accepted pixel at (row,col) completes a window when row>=K-1 and col>=K-1.
  - Next cycle: o_win_valid=1, o_win_xor lane n = window[n] ^ {bW{kbits[n]}}, o_win_row=row-(K-1), o_win_col=col-(K-1).
  - Latency: 1 cycle.
- Output hold: o_win_valid and all output fields hold stable until i_win_ready. If i_win_ready and a new completing pixel are accepted in the same cycle, the new window loads with no bubble.
- Kernel latch: kbits are captured from i_kernel_bits on the first accepted pixel of a frame (row=0, col=0). Changes mid-frame are ignored.
- FSM:
  - FILL: row<K-1. No windows produced. Transition to RUN when row reaches K-1.
  - RUN: windows produced per the rules above. Transition to DONE when pixel (IMG_H-1, IMG_W-1) is accepted.
  - DONE: o_pix_ready=0. Once the last window has handshaked, pulse o_frame_done for 1 cycle, clear counters, return to FILL.
- Boundaries:
  - Pixels with col<K-1 in RUN are accepted and produce no window.
  - col wrap and row increment happen in the same cycle.
  - i_pix_valid while o_pix_ready=0 is ignored; the upstream must hold the pixel.
- rst mid-frame: drops any pending window and returns to FILL with row/col=0. No o_frame_done pulse.

Optional Feature:
- Macro: CONV1_STALL_CNT_EN.
- Defined: adds output port o_stall_cnt, 16 bits.
  - Increments each cycle o_win_valid && !i_win_ready.
  - Saturates at 16'hFFFF.
  - Clears on rst and on the first pixel accept of each frame.
  - Held after o_frame_done until the next frame starts.
- Undefined: no port and no counter logic. All other behaviour is identical.

Test Plan:
- Pixel value = (row*28+col)&8'hFF, kbits=0, i_win_ready=1:
  - first o_win_valid one cycle after accept #117 (row4,col4);
  - lane0=8'h00, lane24=8'h74;
  - exactly 576 windows, row/col raster 0..23;
  - one o_frame_done.
- Same frame with kbits=25'h1FFFFFF: every lane is the bitwise inverse of the previous case; first window lane0=8'hFF.
- i_win_ready toggled 1-of-3 cycles, pixels always valid:
  - no window lost or duplicated;
  - o_pix_ready=0 exactly while a window is stalled;
  - outputs stable during the stall.
- i_kernel_bits changed after pixel 0: all 576 windows use the kbits sampled at pixel 0.
- rst asserted mid-frame after 300 pixels, then a full frame: no o_frame_done for the aborted frame; the new frame yields 576 correct windows.
- With CONV1_STALL_CNT_EN defined, i_win_ready held 0 for 10 cycles on the first window, then 1: o_stall_cnt=10 at o_frame_done.
